// File: rtl/uart_tx_mmio.sv
//==============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter for a single-cycle CPU.
//               CPU stores to TXDATA push bytes into a small circular FIFO.
//               A serialiser drains the FIFO onto tx at a fixed bit period.
//               STATUS and CTRL reads are combinational so a load completes
//               in the same cycle.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               MemWrite   - store strobe
//               Mem_WrAddr - load/store address (decode on [31:4], [3:2])
//               Mem_WrData - store data
//               Sel        - address falls in this block's 16-byte window
//               ReadData   - combinational register read, 0 when not selected
//               tx         - registered serial line, idles high
//               busy       - serialiser is not idle
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic        Sel,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic [1:0] w_off;
    logic       w_wr;
    logic       w_push;
    logic       w_wr_status;
    logic       w_wr_ctrl;

    assign Sel         = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = Mem_WrAddr[3:2];
    assign w_wr        = MemWrite & Sel;
    assign w_push      = w_wr & (w_off == 2'd0);
    assign w_wr_status = w_wr & (w_off == 2'd1);
    assign w_wr_ctrl   = w_wr & (w_off == 2'd2);

    // Address bits [1:0] and upper store-data bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, Mem_WrAddr[1:0], Mem_WrData[31:8]};

    // ------------------------------------------------------------------
    // FIFO and control registers
    // ------------------------------------------------------------------
    logic [7:0]          fifo_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [c_FCNT_W-1:0] count_q;
    logic                ovf_q;
    logic                en_q;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push that arrives while full.
    assign w_full    = (count_q == c_FIFO_FULL);
    assign w_empty   = (count_q == '0);
    assign w_push_ok = w_push & ~w_full;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            fifo_q[wr_ptr_q] <= Mem_WrData[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b1;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_q <= count_q + c_FCNT_W'(1);
                2'b01:   count_q <= count_q - c_FCNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A dropped push outranks a same-cycle clear.
            if (w_push & w_full) begin
                ovf_q <= 1'b1;
            end else if (w_wr_status & Mem_WrData[3]) begin
                ovf_q <= 1'b0;
            end
            if (w_wr_ctrl) begin
                en_q <= Mem_WrData[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               w_tick;

    assign w_tick = (cnt_q == c_BIT_LAST);

    // State register; tx and busy are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            c_S_IDLE: begin
                if (en_q && !w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = c_S_START;
                end
            end
            c_S_START: begin
                cnt_d = w_tick ? '0 : cnt_q + c_CNT_W'(1);
                if (w_tick) begin
                    idx_d   = '0;
                    state_d = c_S_DATA;
                end
            end
            c_S_DATA: begin
                cnt_d = w_tick ? '0 : cnt_q + c_CNT_W'(1);
                if (w_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = c_S_STOP;
                    end
                end
            end
            c_S_STOP: begin
                cnt_d = w_tick ? '0 : cnt_q + c_CNT_W'(1);
                if (w_tick) begin
                    state_d = c_S_IDLE;
                end
            end
            default: state_d = c_S_IDLE;
        endcase
    end

    // Output logic, computed from the next state so that tx and busy
    // change on the same edge as the state they describe.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != c_S_IDLE);
        case (state_d)
            c_S_START: tx_d = 1'b0;
            c_S_DATA:  tx_d = shift_d[0];
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Combinational read port
    // ------------------------------------------------------------------
    logic [3:0] w_cnt4;
    assign w_cnt4 = 4'(count_q);

    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (w_off)
                2'd1:    ReadData = {24'd0, w_cnt4, ovf_q, busy_q, w_empty, w_full};
                2'd2:    ReadData = {31'd0, en_q};
                default: ReadData = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
//==============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio (CPB=4, depth 4).
//               Stimulus queues expected bytes; a serial-line monitor
//               decodes frames on tx and compares them against the queue.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_mmio;

    localparam logic [31:0] c_BASE = 32'h0000_4000;
    localparam logic [31:0] c_STAT = c_BASE + 32'h4;
    localparam logic [31:0] c_CTRL = c_BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic        Sel;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] exp_q [$];
    time        starts [$];
    time        t_edge;

    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;
    logic [2:0] mon_bi;
    logic [7:0] mon_exp;

    uart_tx_mmio #(
        .BASE_ADDR    (c_BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .Sel        (Sel),
        .ReadData   (ReadData),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Store: held for one cycle, sampled at the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite   = 1'b1;
        Mem_WrAddr = a;
        Mem_WrData = d;
        @(posedge clk);
        t_edge = $time;
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        MemWrite   = 1'b0;
        Mem_WrAddr = a;
        #1;
        d = ReadData;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc);
        int k = 0;
        while ((exp_q.size() != 0 || busy || mon_active) && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (k >= max_cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: timeout after %0d cycles, %0d frames outstanding", k, exp_q.size());
        end
    endtask

    // Serial monitor: start detected at the first low sample; bit i is
    // sampled near the middle of its cell, stop bit likewise.
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                starts.push_back($time);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0) begin
                mon_bi           = 3'((mon_cnt - 5) / 4);
                mon_byte[mon_bi] = tx;
            end
            if (mon_cnt == 37) begin
                mon_active = 1'b0;
                check("stop_bit", {31'd0, tx}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame: unexpected byte 0x%0h on tx", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          busy_cnt;

        reset      = 1'b1;
        MemWrite   = 1'b0;
        Mem_WrAddr = '0;
        Mem_WrData = '0;
        idle(3);
        reset = 1'b0;

        // Reset state
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rd(c_STAT, r); check("rst_status", r, 32'h02);
        rd(c_CTRL, r); check("rst_ctrl", r, 32'h01);

        // Single byte
        starts.delete();
        wr(c_BASE, 32'h55);
        exp_q.push_back(8'h55);
        rd(c_STAT, r); check("push_status", r, 32'h10);
        busy_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 32'd40);
        check("frames_1", starts.size(), 32'd1);
        if (starts.size() > 0) check("start_latency", 32'(starts[0] - t_edge), 32'd15);
        wait_done(100);
        rd(c_STAT, r); check("single_status", r, 32'h02);

        // Overflow
        starts.delete();
        for (int i = 1; i <= 6; i++) begin
            wr(c_BASE, 32'(i * 8'h11));
            if (i <= 5) exp_q.push_back(8'(i * 8'h11));
        end
        rd(c_STAT, r); check("ovf_status", r, 32'h4D);
        wr(c_STAT, 32'h8);
        rd(c_STAT, r); check("ovf_clear", r, 32'h45);
        wait_done(400);
        check("frames_5", starts.size(), 32'd5);
        for (int i = 1; i < starts.size(); i++) begin
            check("frame_spacing", 32'(starts[i] - starts[i-1]), 32'd410);
        end

        // Enable gating
        wr(c_BASE, 32'hA0);
        wr(c_BASE, 32'h3C);
        wr(c_BASE, 32'h81);
        exp_q.push_back(8'hA0);
        idle(10);
        wr(c_CTRL, 32'h0);
        wait_done(200);
        idle(20);
        check("gated_busy", {31'd0, busy}, 32'd0);
        rd(c_STAT, r); check("gated_status", r, 32'h20);
        rd(c_CTRL, r); check("gated_ctrl", r, 32'h00);
        wr(c_CTRL, 32'h1);
        check("reenable_busy0", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        idle(1);
        check("reenable_busy1", {31'd0, busy}, 32'd1);
        wait_done(300);
        rd(c_STAT, r); check("reenable_status", r, 32'h02);

        // Reset mid-frame, during data bit 3 (0xC3 bit3 = 0)
        wr(c_BASE, 32'hC3);
        exp_q.push_back(8'hC3);
        repeat (18) @(posedge clk);
        #3;
        check("pre_rst_tx", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(c_STAT, r); check("midrst_status", r, 32'h02);
        rd(c_CTRL, r); check("midrst_ctrl", r, 32'h01);

        // Decode
        rd(c_BASE + 32'h10, r);
        check("dec_sel_out", {31'd0, Sel}, 32'd0);
        check("dec_rd_out", r, 32'h0);
        wr(c_BASE + 32'h10, 32'h99);
        rd(c_BASE + 32'hC, r);
        check("dec_sel_rsvd", {31'd0, Sel}, 32'd1);
        check("dec_rd_rsvd", r, 32'h0);
        wr(c_BASE + 32'hC, 32'hFF);
        rd(c_BASE + 32'h7, r); check("dec_status", r, 32'h02);
        idle(10);
        check("dec_busy", {31'd0, busy}, 32'd0);

        // Simultaneous push and pop
        wr(c_BASE, 32'h5A);
        wr(c_BASE, 32'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        rd(c_STAT, r); check("pushpop_status", r, 32'h14);
        wait_done(300);
        rd(c_STAT, r); check("final_status", r, 32'h02);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
